div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Issue/sequencing stage directly upstream of the iterative RV32M divider.
- Accepts one DIV/DIVU/REM/REMU request from the execute stage and decodes funct3 into the divider's one-hot op strobes.
- Holds operands stable, fires a single start pulse, waits for the divider's valid, then returns the result and destination register to writeback.
- Owns the pipeline stall for the whole operation and handles flush and timeout.

Parameters:
TIMEOUT_CYCLES, 64, WAIT-state cycles allowed before the operation is abandoned with result 0.
CNT_W, 7, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
req_valid_i  input  1  request present from execute
req_ready_o  output  1  block can accept a request (high only in IDLE)
funct3_i  input  3  M-ext funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val_i  input  32  dividend
rs2_val_i  input  32  divisor
rd_i  input  5  destination register
flush_i  input  1  synchronous abort of any in-flight operation
div_start_o  output  1  one-cycle start pulse to the divider
div_op1_o  output  32  latched dividend
div_op2_o  output  32  latched divisor
div_is_div_o, div_is_divu_o, div_is_rem_o, div_is_remu_o  output  1 each  one-hot op strobes, held from ISSUE through WAIT
div_valid_i  input  1  divider result ready
div_result_i  input  32  divider result
resp_valid_o  output  1  response available
resp_ready_i  input  1  writeback consumes response
resp_data_o  output  32  result
resp_rd_o  output  5  destination register
stall_o  output  1  stall execute; high whenever state != IDLE
illegal_o  output  1  one-cycle pulse: request with funct3[2]=0
timeout_o  output  1  one-cycle pulse: divider timed out

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-high on rst_i.
  - Reset forces state IDLE, counter 0, and all latched registers to 0.
  - After reset all outputs are 0, except req_ready_o = 1.
  - Reset mid-operation discards the operation; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On req_valid_i, latch rs1, rs2, funct3, rd.
  - If funct3[2]=0: go to RESP with data 0 and pulse illegal_o.
  - Fast-path hit (feature enabled): go to RESP.
  - Otherwise: go to ISSUE.
- ISSUE: div_start_o=1 for exactly this cycle, strobes valid; clear counter; go to WAIT.
- WAIT:
  - Increment counter each cycle.
  - div_valid_i=1: latch div_result_i into resp data, go to RESP.
  - Counter == TIMEOUT_CYCLES-1 with no valid: data 0, pulse timeout_o, go to RESP.
  - div_valid_i wins over timeout in the same cycle.
- RESP:
  - resp_valid_o=1; data and rd held stable until resp_ready_i.
  - On the resp_ready_i cycle go to IDLE. stall_o drops the following cycle.
- Latency:
  - Normal path: accept at N, start at N+1, resp_valid_o on the cycle after div_valid_i.
  - Illegal/fast path: resp_valid_o at N+1.
- flush_i:
  - From any non-IDLE state: go to IDLE next cycle, drop the response, deassert strobes.
  - Any div_valid_i arriving later is ignored.
  - flush_i beats resp_ready_i and req_valid_i.
- Ignore rules:
  - div_valid_i outside WAIT is ignored.
  - req_valid_i outside IDLE is ignored (req_ready_o=0).

Optional Feature:
- Macro: DIV_SPECIAL_CASE_FASTPATH_EN.
- Defined: IDLE resolves the RISC-V special cases locally, with no divider start.
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Undefined: every legal request goes through ISSUE/WAIT and resp_data_o = div_result_i unmodified.

Test Plan:
1. DIVU 100/7 (funct3 101): one div_start_o pulse, strobes {0,1,0,0}; divider returns 14 after 33 cycles -> resp_valid_o with 14, rd echoed; stall_o high from accept until after the handshake.
2. REM -7/2 (funct3 110), resp_ready_i held low 5 cycles -> resp_data_o holds divider value 0xFFFFFFFF stable; IDLE one cycle after ready.
3. Fast path enabled, DIV 5/0 -> no div_start_o; resp at N+1 = 0xFFFFFFFF. REM 0x80000000/0xFFFFFFFF -> 0. Disabled -> both issue to the divider.
4. Divider never asserts valid, TIMEOUT_CYCLES=64 -> timeout_o pulse after 64 WAIT cycles; resp 0.
5. flush_i asserted in WAIT, then div_valid_i two cycles later -> no resp_valid_o; req_ready_o=1 the cycle after flush.
6. funct3 000 -> illegal_o pulse, resp 0 at N+1. rst_i asserted mid-WAIT -> outputs 0 immediately, req_ready_o=1.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Execute/divider/writeback bundle around the divider issue controller.
// The slave view belongs to the controller; the master view belongs to everything around it.
interface div_issue_ctrl_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_val_i;
    logic [31:0] rs2_val_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        div_start_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_is_div_o;
    logic        div_is_divu_o;
    logic        div_is_rem_o;
    logic        div_is_remu_o;
    logic        div_valid_i;
    logic [31:0] div_result_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        stall_o;
    logic        illegal_o;
    logic        timeout_o;

    modport slave (
        input  req_valid_i, funct3_i, rs1_val_i, rs2_val_i, rd_i, flush_i,
               div_valid_i, div_result_i, resp_ready_i,
        output req_ready_o, div_start_o, div_op1_o, div_op2_o,
               div_is_div_o, div_is_divu_o, div_is_rem_o, div_is_remu_o,
               resp_valid_o, resp_data_o, resp_rd_o, stall_o, illegal_o, timeout_o
    );

    modport master (
        output req_valid_i, funct3_i, rs1_val_i, rs2_val_i, rd_i, flush_i,
               div_valid_i, div_result_i, resp_ready_i,
        input  req_ready_o, div_start_o, div_op1_o, div_op2_o,
               div_is_div_o, div_is_divu_o, div_is_rem_o, div_is_remu_o,
               resp_valid_o, resp_data_o, resp_rd_o, stall_o, illegal_o, timeout_o
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// RV32M divide issue/sequencer: start at N+1, response the cycle after div_valid (N+1 for illegal/fast path);
// one op in flight, stalls execute until writeback takes the response. DIV_SPECIAL_CASE_FASTPATH_EN resolves x/0 and overflow locally.
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    div_issue_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        op1_q, op2_q;
    logic [1:0]         op_q;
    logic [4:0]         rd_q;
    logic [31:0]        data_q, data_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic               ld_req;
    logic               strobe_en;

    logic               fast_hit;
    logic [31:0]        fast_data;

`ifdef DIV_SPECIAL_CASE_FASTPATH_EN
    // Divide-by-zero and signed overflow have fixed RISC-V results; no need to occupy the divider.
    always_comb begin
        fast_hit  = 1'b0;
        fast_data = '0;
        if (bus.rs2_val_i == 32'h0) begin
            fast_hit  = 1'b1;
            fast_data = bus.funct3_i[1] ? bus.rs1_val_i : 32'hFFFF_FFFF;
        end else if (!bus.funct3_i[0] && bus.rs1_val_i == 32'h8000_0000
                     && bus.rs2_val_i == 32'hFFFF_FFFF) begin
            fast_hit  = 1'b1;
            fast_data = bus.funct3_i[1] ? 32'h0 : 32'h8000_0000;
        end
    end
`else
    assign fast_hit  = 1'b0;
    assign fast_data = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        ld_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    ld_req = 1'b1;
                    if (!bus.funct3_i[2]) begin
                        state_d   = RESP;
                        data_d    = '0;
                        illegal_d = 1'b1;
                    end else if (fast_hit) begin
                        state_d = RESP;
                        data_d  = fast_data;
                    end else begin
                        state_d = ISSUE;
                        data_d  = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result landing on the last allowed cycle still counts.
                if (bus.div_valid_i) begin
                    data_d  = bus.div_result_i;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    data_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i && state_q != IDLE) begin
            state_d   = IDLE;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (ld_req) begin
                op1_q <= bus.rs1_val_i;
                op2_q <= bus.rs2_val_i;
                op_q  <= bus.funct3_i[1:0];
                rd_q  <= bus.rd_i;
            end
        end
    end

    assign strobe_en = (state_q == ISSUE) || (state_q == WAIT);

    assign bus.req_ready_o   = (state_q == IDLE);
    assign bus.stall_o       = (state_q != IDLE);
    assign bus.div_start_o   = (state_q == ISSUE);
    assign bus.div_op1_o     = op1_q;
    assign bus.div_op2_o     = op2_q;
    assign bus.div_is_div_o  = strobe_en && (op_q == 2'b00);
    assign bus.div_is_divu_o = strobe_en && (op_q == 2'b01);
    assign bus.div_is_rem_o  = strobe_en && (op_q == 2'b10);
    assign bus.div_is_remu_o = strobe_en && (op_q == 2'b11);
    assign bus.resp_valid_o  = (state_q == RESP);
    assign bus.resp_data_o   = data_q;
    assign bus.resp_rd_o     = rd_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: transaction-level reference model checked every cycle plus literal spot checks.
module tb_div_issue_ctrl;
    localparam int TIMEOUT = 64;
`ifdef DIV_SPECIAL_CASE_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   n_start;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RISC-V fixed results for x/0 and signed overflow; bit 32 flags a special case.
    function automatic logic [32:0] special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0)
            return {1'b1, (f3[1] ? a : 32'hFFFF_FFFF)};
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, (f3[1] ? 32'h0 : 32'h8000_0000)};
        return 33'h0;
    endfunction

    // Reference model: one transaction at a time, tracked by age since acceptance.
    bit          m_busy, m_issued, m_resp, m_ill, m_to;
    int          m_age;
    logic [31:0] m_data, m_op1, m_op2;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [32:0] sp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_issued = 0; m_resp = 0; m_ill = 0; m_to = 0; m_age = 0;
            m_data = '0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_f3 = '0;
        end else begin
            m_ill = 0;
            m_to  = 0;
            if (bus.flush_i && m_busy) begin
                m_busy = 0; m_resp = 0; m_issued = 0;
            end else if (!m_busy) begin
                if (bus.req_valid_i && !bus.flush_i) begin
                    m_busy = 1; m_age = 0;
                    m_op1 = bus.rs1_val_i; m_op2 = bus.rs2_val_i;
                    m_f3 = bus.funct3_i; m_rd = bus.rd_i;
                    sp = special(m_f3, m_op1, m_op2);
                    if (!m_f3[2]) begin
                        m_resp = 1; m_issued = 0; m_data = '0; m_ill = 1;
                    end else if (FAST && sp[32]) begin
                        m_resp = 1; m_issued = 0; m_data = sp[31:0];
                    end else begin
                        m_resp = 0; m_issued = 1;
                    end
                end
            end else if (m_resp) begin
                if (bus.resp_ready_i) begin
                    m_busy = 0; m_resp = 0; m_issued = 0;
                end
            end else begin
                m_age++;
                if (m_age >= 2) begin
                    if (bus.div_valid_i) begin
                        m_resp = 1; m_data = bus.div_result_i;
                    end else if (m_age - 1 == TIMEOUT) begin
                        m_resp = 1; m_data = '0; m_to = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 32'(bus.req_ready_o), 32'(!m_busy));
            chk("stall", 32'(bus.stall_o), 32'(m_busy));
            chk("div_start", 32'(bus.div_start_o), 32'(m_busy && m_issued && !m_resp && m_age == 0));
            chk("strobes", 32'({bus.div_is_div_o, bus.div_is_divu_o, bus.div_is_rem_o, bus.div_is_remu_o}),
                32'((m_busy && m_issued && !m_resp) ? (4'b1000 >> m_f3[1:0]) : 4'b0000));
            chk("resp_valid", 32'(bus.resp_valid_o), 32'(m_resp));
            chk("illegal", 32'(bus.illegal_o), 32'(m_ill));
            chk("timeout", 32'(bus.timeout_o), 32'(m_to));
            chk("op1", bus.div_op1_o, m_op1);
            chk("op2", bus.div_op2_o, m_op2);
            if (m_resp) begin
                chk("resp_data", bus.resp_data_o, m_data);
                chk("resp_rd", 32'(bus.resp_rd_o), 32'(m_rd));
            end
            if (bus.div_start_o) n_start++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after acceptance (ISSUE, or RESP for illegal/fast path).
    task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.req_valid_i = 1'b1;
        bus.funct3_i    = f3;
        bus.rs1_val_i   = a;
        bus.rs2_val_i   = b;
        bus.rd_i        = rd;
        step();
        bus.req_valid_i = 1'b0;
    endtask

    // Called in ISSUE: sits d WAIT cycles, then presents the result for one cycle.
    task automatic div_return(input int d, input logic [31:0] r);
        step();
        repeat (d) step();
        bus.div_valid_i  = 1'b1;
        bus.div_result_i = r;
        step();
        bus.div_valid_i  = 1'b0;
    endtask

    task automatic finish_resp();
        bus.resp_ready_i = 1'b1;
        step();
        bus.resp_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int cnt;
        n_vec = 0; n_bad = 0; n_start = 0;
        rst = 1'b1;
        bus.req_valid_i = 0; bus.funct3_i = '0; bus.rs1_val_i = '0; bus.rs2_val_i = '0;
        bus.rd_i = '0; bus.flush_i = 0; bus.div_valid_i = 0; bus.div_result_i = '0; bus.resp_ready_i = 0;
        step();
        chk("reset req_ready", 32'(bus.req_ready_o), 32'd1);
        chk("reset stall", 32'(bus.stall_o), 32'd0);
        chk("reset resp_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("reset op1", bus.div_op1_o, 32'd0);
        rst = 1'b0;
        step();

        // DIVU 100/7 -> 14 after 33 WAIT cycles
        s0 = n_start;
        send_req(3'b101, 32'd100, 32'd7, 5'd5);
        chk("t1 start", 32'(bus.div_start_o), 32'd1);
        chk("t1 strobes", 32'({bus.div_is_div_o, bus.div_is_divu_o, bus.div_is_rem_o, bus.div_is_remu_o}), 32'h4);
        chk("t1 stall", 32'(bus.stall_o), 32'd1);
        div_return(32, 32'd14);
        chk("t1 resp_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("t1 data", bus.resp_data_o, 32'd14);
        chk("t1 rd", 32'(bus.resp_rd_o), 32'd5);
        chk("t1 start count", 32'(n_start - s0), 32'd1);
        chk("t1 stall held", 32'(bus.stall_o), 32'd1);
        finish_resp();
        chk("t1 stall drop", 32'(bus.stall_o), 32'd0);

        // REM -7/2 with writeback stalling 5 cycles
        send_req(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9);
        div_return(0, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("t2 data held", bus.resp_data_o, 32'hFFFF_FFFF);
            chk("t2 valid held", 32'(bus.resp_valid_o), 32'd1);
            step();
        end
        finish_resp();
        chk("t2 idle", 32'(bus.req_ready_o), 32'd1);

        // Special cases
        s0 = n_start;
        send_req(3'b100, 32'd5, 32'd0, 5'd3);
        if (FAST) begin
            chk("t3 div0 resp", 32'(bus.resp_valid_o), 32'd1);
            chk("t3 div0 data", bus.resp_data_o, 32'hFFFF_FFFF);
        end else begin
            chk("t3 div0 issued", 32'(bus.div_start_o), 32'd1);
            div_return(3, 32'hFFFF_FFFF);
            chk("t3 div0 data", bus.resp_data_o, 32'hFFFF_FFFF);
        end
        finish_resp();
        send_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
        if (FAST) begin
            chk("t3 ovf data", bus.resp_data_o, 32'h0);
            chk("t3 no start", 32'(n_start - s0), 32'd0);
        end else begin
            div_return(2, 32'h0);
            chk("t3 ovf data", bus.resp_data_o, 32'h0);
            chk("t3 two starts", 32'(n_start - s0), 32'd2);
        end
        finish_resp();

        // Divider never answers
        send_req(3'b101, 32'd10, 32'd3, 5'd7);
        step();
        cnt = 0;
        while (!bus.timeout_o && cnt < 100) begin
            step();
            cnt++;
        end
        chk("t4 wait cycles", 32'(cnt), 32'd64);
        chk("t4 data", bus.resp_data_o, 32'd0);
        chk("t4 resp_valid", 32'(bus.resp_valid_o), 32'd1);
        finish_resp();
        chk("t4 pulse ends", 32'(bus.timeout_o), 32'd0);

        // Flush in WAIT, stale divider result afterwards
        send_req(3'b111, 32'd9, 32'd4, 5'd2);
        step();
        step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("t5 ready", 32'(bus.req_ready_o), 32'd1);
        chk("t5 no resp", 32'(bus.resp_valid_o), 32'd0);
        step();
        bus.div_valid_i = 1'b1;
        bus.div_result_i = 32'd2;
        step();
        bus.div_valid_i = 1'b0;
        chk("t5 stale ignored", 32'(bus.resp_valid_o), 32'd0);
        chk("t5 stall", 32'(bus.stall_o), 32'd0);

        // Illegal funct3
        send_req(3'b000, 32'd1, 32'd2, 5'd4);
        chk("t6 illegal", 32'(bus.illegal_o), 32'd1);
        chk("t6 resp_valid", 32'(bus.resp_valid_o), 32'd1);
        chk("t6 data", bus.resp_data_o, 32'd0);
        finish_resp();
        chk("t6 illegal ends", 32'(bus.illegal_o), 32'd0);

        // Flush beats resp_ready
        send_req(3'b011, 32'd1, 32'd2, 5'd8);
        bus.flush_i = 1'b1;
        bus.resp_ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.resp_ready_i = 1'b0;
        chk("t7 ready", 32'(bus.req_ready_o), 32'd1);
        chk("t7 no resp", 32'(bus.resp_valid_o), 32'd0);

        // Reset mid-WAIT
        send_req(3'b101, 32'd50, 32'd5, 5'd6);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("t8 ready", 32'(bus.req_ready_o), 32'd1);
        chk("t8 stall", 32'(bus.stall_o), 32'd0);
        chk("t8 strobes", 32'({bus.div_is_div_o, bus.div_is_divu_o, bus.div_is_rem_o, bus.div_is_remu_o}), 32'h0);
        chk("t8 op1", bus.div_op1_o, 32'd0);
        chk("t8 rd", 32'(bus.resp_rd_o), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("t8 after reset", 32'(bus.resp_valid_o), 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
